// File: rtl/tile_lane_engine_pkg.sv
// Shared types and default geometry for the falling-tile engine.
package tile_pkg;

  typedef enum logic {IDLE, FALL} lane_state_t;

  localparam int unsigned TILE_H_DEF    = 75;
  localparam int unsigned Y_MIN_DEF     = 0;
  localparam int unsigned Y_MAX_DEF     = 479;
  localparam int unsigned PARK_Y_DEF    = 480;
  localparam int unsigned BASE_STEP_DEF = 3;
  localparam int unsigned HIT_LO_DEF    = 380;

endpackage

// File: rtl/tile_lane_engine_lane.sv
// One lane: IDLE/FALL state machine, y and motion registers, hit/miss pulses.
module tile_lane
  import tile_pkg::*;
#(
  parameter int unsigned TILE_H    = TILE_H_DEF,
  parameter int unsigned Y_MIN     = Y_MIN_DEF,
  parameter int unsigned Y_MAX     = Y_MAX_DEF,
  parameter int unsigned PARK_Y    = PARK_Y_DEF,
  parameter int unsigned BASE_STEP = BASE_STEP_DEF,
  parameter int unsigned HIT_LO    = HIT_LO_DEF,
  parameter int unsigned SPEED_W   = 4
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               spawn_en,
  input  logic [SPEED_W-1:0] speed,
  input  logic               key_press,
  output logic [9:0]         y,
  output logic               active,
  output logic               hit,
  output logic               miss
);

  lane_state_t state_q, state_d;
  logic [9:0]  y_q, y_d, mot_q, mot_d;
  logic        hit_d, miss_d;
  logic [10:0] bottom;

  // Bottom edge at 11 bits so the window compares never wrap.
  assign bottom = {1'b0, y_q} + 11'(TILE_H);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    mot_d   = mot_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn_en) begin
          y_d     = 10'(Y_MIN);
          mot_d   = 10'(BASE_STEP) + 10'(speed);
          state_d = FALL;
        end
      end
      FALL: begin
        if (key_press && (bottom >= 11'(HIT_LO))) begin
          hit_d   = 1'b1;
          y_d     = 10'(PARK_Y);
          state_d = IDLE;
        end else if (bottom >= 11'(Y_MAX)) begin
          miss_d  = 1'b1;
          y_d     = 10'(PARK_Y);
          state_d = IDLE;
        end else begin
          y_d = y_q + mot_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      y_q     <= 10'(PARK_Y);
      mot_q   <= '0;
      hit     <= 1'b0;
      miss    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      mot_q   <= mot_d;
      hit     <= hit_d;
      miss    <= miss_d;
    end
  end

  assign y      = y_q;
  assign active = (state_q == FALL);

endmodule

// File: rtl/tile_lane_engine.sv
// Multi-lane falling-tile engine: spawn decode, per-lane tiles, hit/miss scoring.
module tile_lane_engine
  import tile_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned LANE_W    = 160,
  parameter int unsigned TILE_H    = TILE_H_DEF,
  parameter int unsigned Y_MIN     = Y_MIN_DEF,
  parameter int unsigned Y_MAX     = Y_MAX_DEF,
  parameter int unsigned BASE_STEP = BASE_STEP_DEF,
  parameter int unsigned SPEED_W   = 4,
  parameter int unsigned HIT_LO    = HIT_LO_DEF,
  parameter int unsigned PARK_Y    = PARK_Y_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic                         spawn,
  input  logic [$clog2(NUM_LANES)-1:0] spawn_lane,
  input  logic [SPEED_W-1:0]           speed,
  input  logic [NUM_LANES-1:0]         key_press,
  output logic [NUM_LANES*10-1:0]      tile_x,
  output logic [NUM_LANES*10-1:0]      tile_y,
  output logic [9:0]                   tile_s,
  output logic [NUM_LANES-1:0]         active,
  output logic [NUM_LANES-1:0]         hit,
  output logic [NUM_LANES-1:0]         miss,
  output logic                         spawn_drop,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int unsigned LANE_IW = $clog2(NUM_LANES);
  localparam int unsigned POP_W   = $clog2(NUM_LANES + 1);
  localparam int unsigned SUM_W   = CNT_W + POP_W;

  logic [NUM_LANES-1:0] lane_spawn;
  logic                 drop_d;
  logic [POP_W-1:0]     hit_pop, miss_pop;
  logic [SUM_W-1:0]     hit_sum, miss_sum;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_spawn[i]     = spawn && (spawn_lane == LANE_IW'(i));
    assign tile_x[i*10 +: 10] = 10'(i * LANE_W);

    tile_lane #(
      .TILE_H    (TILE_H),
      .Y_MIN     (Y_MIN),
      .Y_MAX     (Y_MAX),
      .PARK_Y    (PARK_Y),
      .BASE_STEP (BASE_STEP),
      .HIT_LO    (HIT_LO),
      .SPEED_W   (SPEED_W)
    ) u_lane (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .spawn_en  (lane_spawn[i]),
      .speed     (speed),
      .key_press (key_press[i]),
      .y         (tile_y[i*10 +: 10]),
      .active    (active[i]),
      .hit       (hit[i]),
      .miss      (miss[i])
    );
  end

  assign tile_s = 10'(TILE_H);

  // A spawn is refused when its lane is out of range or already falling.
  always_comb begin
    drop_d = 1'b0;
    if (spawn) begin
      if (int'(spawn_lane) >= int'(NUM_LANES)) drop_d = 1'b1;
      else                                     drop_d = active[spawn_lane];
    end
  end

  always_comb begin
    hit_pop  = '0;
    miss_pop = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      hit_pop  = hit_pop  + POP_W'(hit[i]);
      miss_pop = miss_pop + POP_W'(miss[i]);
    end
    hit_sum  = SUM_W'(hit_count)  + SUM_W'(hit_pop);
    miss_sum = SUM_W'(miss_count) + SUM_W'(miss_pop);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      spawn_drop <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      spawn_drop <= drop_d;
      hit_count  <= (hit_sum  > SUM_W'({CNT_W{1'b1}})) ? '1 : hit_sum[CNT_W-1:0];
      miss_count <= (miss_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : miss_sum[CNT_W-1:0];
    end
  end

endmodule
